// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - period monitor for a divided clock: measures rise-to-rise
// periods in clk cycles, declares lock after a run of good periods, flags deviations.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 3,
  parameter int TOL        = 0,
  parameter int LOCK_CNT   = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam logic [CNT_W-1:0] PMAX  = '1;
  localparam logic [ERR_W-1:0] EMAX  = '1;
  localparam logic [CNT_W:0]   EXP_X = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_X = (CNT_W+1)'(TOL);

  typedef enum logic [1:0] {IDLE, ARM, TRACK, LOCKED} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [CNT_W-1:0] pcnt;
  logic [RUN_W-1:0] run;

  logic             rise;
  logic             tracking;
  logic             timeout;
  logic             good;
  logic             run_last;
  logic             err_hit;
  logic [CNT_W:0]   pcnt_x;
  logic [CNT_W:0]   dev;

  assign rise     = s2 & ~s3;
  assign tracking = (state == TRACK) || (state == LOCKED);
  assign timeout  = tracking && !rise && (pcnt == PMAX);

  // One extra bit so the absolute deviation never wraps.
  assign pcnt_x   = {1'b0, pcnt};
  assign dev      = (pcnt_x >= EXP_X) ? (pcnt_x - EXP_X) : (EXP_X - pcnt_x);
  assign good     = (dev <= TOL_X);
  assign run_last = (run == RUN_W'(LOCK_CNT - 1));
  assign err_hit  = en && (state == LOCKED) && ((rise && !good) || timeout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      pcnt       <= '0;
      run        <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      s1         <= clk_in;
      s2         <= s1;
      s3         <= s2;
      period_vld <= 1'b0;
      err        <= err_hit;

      if (err_clr) begin
        err_cnt <= '0;
      end else if (err_hit && (err_cnt != EMAX)) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if (!en) begin
        state  <= IDLE;
        pcnt   <= '0;
        run    <= '0;
        locked <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= ARM;
            pcnt  <= '0;
            run   <= '0;
          end
          // First edge only opens the measurement window.
          ARM: begin
            if (rise) begin
              state <= TRACK;
              pcnt  <= CNT_W'(1);
            end else if (pcnt != PMAX) begin
              pcnt <= pcnt + 1'b1;
            end
          end
          TRACK, LOCKED: begin
            if (rise) begin
              pcnt       <= CNT_W'(1);
              period     <= pcnt;
              period_vld <= 1'b1;
              if (!good) begin
                run    <= '0;
                locked <= 1'b0;
                state  <= TRACK;
              end else if (state == TRACK) begin
                if (run_last) begin
                  run    <= '0;
                  locked <= 1'b1;
                  state  <= LOCKED;
                end else begin
                  run <= run + 1'b1;
                end
              end
            end else if (timeout) begin
              period     <= PMAX;
              period_vld <= 1'b1;
              pcnt       <= '0;
              run        <= '0;
              locked     <= 1'b0;
              state      <= ARM;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - table-driven scoreboard bench for clk_div_monitor
// dut0: CNT_W=4, ERR_W=2, TOL=0; dut1: defaults with TOL=1.
module tb_clk_div_monitor;

  typedef struct {
    int phase;
    int gap;
    bit rep;
    int per;
    bit lck;
    bit er;
    int ecnt;
    bit clr;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       clk_in0, clk_in1;
  logic       en0, en1;
  logic       err_clr;
  logic [3:0] period0;
  logic       period_vld0, locked0, err0;
  logic [1:0] err_cnt0;
  logic [7:0] period1;
  logic       period_vld1, locked1, err1;
  logic [7:0] err_cnt1;

  vec_t tbl[$];
  vec_t q0[$];
  vec_t q1[$];
  vec_t e0, e1;
  int   sel;
  int   n_checks;
  int   n_fail;

  clk_div_monitor #(.CNT_W(4), .EXP_PERIOD(3), .TOL(0), .LOCK_CNT(4), .ERR_W(2)) dut0 (
    .clk(clk), .rst(rst), .clk_in(clk_in0), .en(en0), .err_clr(err_clr),
    .period(period0), .period_vld(period_vld0), .locked(locked0), .err(err0),
    .err_cnt(err_cnt0)
  );

  clk_div_monitor #(.CNT_W(8), .EXP_PERIOD(3), .TOL(1), .LOCK_CNT(4), .ERR_W(8)) dut1 (
    .clk(clk), .rst(rst), .clk_in(clk_in1), .en(en1), .err_clr(err_clr),
    .period(period1), .period_vld(period_vld1), .locked(locked1), .err(err1),
    .err_cnt(err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int ph, input int gap, input bit rep, input int per,
                              input bit lck, input bit er, input int ecnt, input bit clr);
    vec_t v;
    v.phase = ph; v.gap = gap; v.rep = rep; v.per = per;
    v.lck = lck; v.er = er; v.ecnt = ecnt; v.clr = clr;
    tbl.push_back(v);
  endfunction

  task automatic step(input bit v, input bit c);
    @(negedge clk);
    if (sel == 0) clk_in0 = v;
    else clk_in1 = v;
    err_clr = c;
  endtask

  task automatic run_phase(input int p);
    bit pend;
    pend = 1'b0;
    foreach (tbl[i]) begin
      if (tbl[i].phase == p) begin
        for (int j = 1; j < tbl[i].gap; j++) step(1'b0, pend && (j == 2));
        step(1'b1, 1'b0);
        if (tbl[i].rep) begin
          if (sel == 0) q0.push_back(tbl[i]);
          else q1.push_back(tbl[i]);
        end
        pend = tbl[i].clr;
      end
    end
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 12; i++) begin
      if (((d == 0) ? q0.size() : q1.size()) == 0) break;
      step(1'b0, 1'b0);
    end
    check((d == 0) ? "dut0_drain" : "dut1_drain", (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (period_vld0) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut0_unexpected_vld: got period_vld=1 period=%0d, expected no report", period0);
        end else begin
          e0 = q0.pop_front();
          check("dut0_period", period0, e0.per);
          check("dut0_locked", locked0, e0.lck);
          check("dut0_err", err0, e0.er);
          check("dut0_err_cnt", err_cnt0, e0.ecnt);
        end
      end else begin
        check("dut0_err_idle", err0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (period_vld1) begin
        if (q1.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dut1_unexpected_vld: got period_vld=1 period=%0d, expected no report", period1);
        end else begin
          e1 = q1.pop_front();
          check("dut1_period", period1, e1.per);
          check("dut1_locked", locked1, e1.lck);
          check("dut1_err", err1, e1.er);
          check("dut1_err_cnt", err_cnt1, e1.ecnt);
        end
      end else begin
        check("dut1_err_idle", err1, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected end within time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    sel      = 0;
    rst      = 1'b1;
    clk_in0  = 1'b0;
    clk_in1  = 1'b0;
    en0      = 1'b0;
    en1      = 1'b0;
    err_clr  = 1'b0;

    // Phase 1, dut1 with TOL=1: 3/4/2 all good, 5 is bad once locked.
    add(1, 3, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 3, 0, 0, 0, 0);
    add(1, 4, 1, 4, 0, 0, 0, 0);
    add(1, 2, 1, 2, 0, 0, 0, 0);
    add(1, 3, 1, 3, 1, 0, 0, 0);
    add(1, 4, 1, 4, 1, 0, 0, 0);
    add(1, 2, 1, 2, 1, 0, 0, 0);
    add(1, 5, 1, 5, 0, 1, 1, 0);
    add(1, 3, 1, 3, 0, 0, 1, 0);
    // Phase 2: clean lock, one stretched period, relock.
    add(2, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(2, 3, 1, 3, (k >= 3), 0, 0, 0);
    add(2, 4, 1, 4, 0, 1, 1, 0);
    for (int k = 0; k < 4; k++) add(2, 3, 1, 3, (k == 3), 0, 1, 0);
    // Phase 3: after timeout the first edge is only an arm edge.
    add(3, 3, 0, 0, 0, 0, 0, 0);
    add(3, 3, 1, 3, 0, 0, 2, 0);
    // Phase 4: five lock/error cycles saturate the 2-bit counter.
    add(4, 3, 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) add(4, 3, 1, 3, (k == 3), 0, (g < 3) ? g : 3, 0);
      add(4, 4, 1, 4, 0, 1, (g + 1 < 3) ? g + 1 : 3, 0);
    end
    for (int k = 0; k < 4; k++) add(4, 3, 1, 3, (k == 3), 0, 3, 0);
    // Phase 5: relock after reset in 5 edges, then err_clr against an err.
    add(5, 3, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(5, 3, 1, 3, (k == 3), 0, 0, 0);
    add(5, 4, 1, 4, 0, 1, 0, 1);
    add(5, 3, 1, 3, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_period0", period0, 0);
    check("rst_vld0", period_vld0, 0);
    check("rst_locked0", locked0, 0);
    check("rst_err0", err0, 0);
    check("rst_err_cnt0", err_cnt0, 0);
    check("rst_period1", period1, 0);
    check("rst_vld1", period_vld1, 0);
    check("rst_locked1", locked1, 0);
    check("rst_err1", err1, 0);
    check("rst_err_cnt1", err_cnt1, 0);
    rst = 1'b0;

    sel = 1;
    en1 = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    run_phase(1);
    drain(1);
    en1 = 1'b0;

    sel = 0;
    en0 = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    run_phase(2);
    drain(0);

    // Hold the input low from LOCKED until the counter runs out.
    q0.push_back('{phase: 0, gap: 0, rep: 1'b1, per: 15, lck: 1'b0, er: 1'b1, ecnt: 2, clr: 1'b0});
    repeat (20) step(1'b0, 1'b0);
    drain(0);
    run_phase(3);
    drain(0);

    // Enable dropped in TRACK: no reports, period held.
    en0 = 1'b0;
    repeat (3) begin
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
    end
    repeat (2) step(1'b0, 1'b0);
    check("en_off_locked", locked0, 0);
    check("en_off_period", period0, 3);
    check("en_off_err_cnt", err_cnt0, 2);
    repeat (2) step(1'b0, 1'b0);
    en0 = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("err_clr_plain", err_cnt0, 0);
    run_phase(4);
    drain(0);

    check("pre_rst_locked", locked0, 1);
    check("pre_rst_err_cnt", err_cnt0, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    check("mid_rst_period", period0, 0);
    check("mid_rst_vld", period_vld0, 0);
    check("mid_rst_locked", locked0, 0);
    check("mid_rst_err", err0, 0);
    check("mid_rst_err_cnt", err_cnt0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    run_phase(5);
    drain(0);

    repeat (4) step(1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Single-clock frequency monitor that consumes the output of the team's divide-by-N clock generators (nominally the divide-by-3 output) and checks that its period matches the expected value. It synchronises the monitored waveform into the `clk` domain, measures every rising-edge-to-rising-edge period in `clk` cycles, declares lock after a run of in-tolerance periods, and flags and counts deviations. It sits directly downstream of the divider, with its status going to the clock-health/CSR logic.

## Interface
- `CNT_W`, 8: width of the period counter and of `period`; max measurable period is 2^CNT_W-1.
- `EXP_PERIOD`, 3: expected period in `clk` cycles.
- `TOL`, 0: allowed absolute deviation; a period is good iff |period-EXP_PERIOD| <= TOL.
- `LOCK_CNT`, 4: consecutive good periods needed to assert `locked` (>=1).
- `ERR_W`, 8: width of `err_cnt`.

Ports:
- `clk` input 1: monitor clock; same frequency as the divider's source clock. Everything is on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clk_in` input 1: monitored divided clock; treated as asynchronous.
- `en` input 1: monitor enable, level.
- `err_clr` input 1: synchronous one-cycle clear of `err_cnt`.
- `period` output CNT_W: last measured period.
- `period_vld` output 1: one-cycle pulse when `period` updates.
- `locked` output 1: level; the period is stable and in tolerance.
- `err` output 1: one-cycle pulse on a bad period while locked.
- `err_cnt` output ERR_W: saturating count of `err` pulses.

## Operation
- Input path: 2-flop synchroniser s1→s2, plus history flop s3. Rising edge detect `rise = s2 & ~s3`.
- Period counter `pcnt`:
  - Increments every cycle in ARM/TRACK/LOCKED.
  - Loads 1 on `rise`.
  - On `rise`, the value presented is `pcnt` (cycles since the previous rise, inclusive).
- FSM states are IDLE, ARM, TRACK and LOCKED.
  - IDLE: `pcnt`=0 and run counter=0. Goes to ARM when `en`=1.
  - ARM: waits for the first `rise`. On `rise`, goes to TRACK with `pcnt`=1. No `period_vld` is emitted, because the first edge has no valid start.
  - TRACK: on each `rise`, emits `period`/`period_vld`.
    - Good period: run++.
    - Good period when run+1 == LOCK_CNT: go to LOCKED and set `locked`=1 on the same edge as that `period_vld`.
    - Bad period: run=0 and stay in TRACK. No `err` is raised.
  - LOCKED: on each `rise`, emits `period`/`period_vld`.
    - Good period: stay in LOCKED.
    - Bad period: pulse `err`, increment `err_cnt`, clear `locked`, clear run, go to TRACK.
  - Timeout (TRACK or LOCKED): if `pcnt` reaches 2^CNT_W-1 with no `rise`, emit `period`=all-ones with `period_vld`, then go to ARM.
    - If the state was LOCKED, also pulse `err`, increment `err_cnt` and drop `locked`.
    - In ARM, `pcnt` saturates and no timeout is raised.
  - `en`=0 in any state: go to IDLE next cycle and drop `locked`. `period` holds its value. `err_cnt` holds its value. No pulses are emitted.
- `err_cnt` saturates at 2^ERR_W-1.
  - `err_clr` has priority over an increment in the same cycle, so the result is 0.
- Arithmetic: the deviation compare is done unsigned at CNT_W+1 bits, so there is no wrap.

## Timing
- Reset values:
  - `period`=0, `period_vld`=0, `locked`=0, `err`=0, `err_cnt`=0.
  - FSM in IDLE; s1, s2, s3, `pcnt` and the run counter all 0.
- `rise` is true in the cycle after `clk_in` has been sampled high by two consecutive edges.
- `period_vld`, `period`, `locked` and `err` are registered. They update on the 3rd `clk` edge, counting the first edge that samples `clk_in` high as edge 1.
- Edge-to-report latency is constant, so periods are exact in `clk` cycles. Synchroniser uncertainty adds at most ±1 cycle to a single period.
- A `rise` and a timeout in the same cycle: the `rise` wins and the period is measured normally.
- Asserting `rst` mid-operation immediately clears all state and outputs, including `err_cnt`.

## Test plan
- Lock on a clean input (defaults):
  - Stimulus: `clk_in` is an ideal period-3 waveform, `en`=1 after reset.
  - Required: first `period_vld` about 3 periods after enable with `period`=3; pulses every 3 cycles; `locked` rises with the 4th `period_vld`; `err_cnt`=0.
- Single bad period while locked:
  - Stimulus: once locked, stretch one period to 4 cycles.
  - Required: `period`=4, one `err` pulse, `err_cnt`=1, `locked`=0; `locked` returns after 4 further good periods.
- Tolerance:
  - Stimulus: TOL=1, periods alternating 3/4/2.
  - Required: `locked` asserts and `err` never fires. A period of 5 gives `err` and `err_cnt`=1.
- Timeout:
  - Stimulus: CNT_W=4; hold `clk_in` low after lock.
  - Required: after 15 cycles, `period`=15, `period_vld`, `err`, `locked`=0, FSM back in ARM; the next edge gives no `period_vld`.
- Enable/clear/saturation:
  - `en` deasserted mid-TRACK → `locked`=0, no pulses, `period` held.
  - ERR_W=2 with 5 errors → `err_cnt`=3.
  - `err_clr` coincident with an `err` → `err_cnt`=0.
- Reset mid-lock:
  - Stimulus: assert `rst` asynchronously between clock edges while locked.
  - Required: all outputs 0 immediately; relock takes 5 edges after reset release.
